// File: rtl/fp_arb_pkg.sv
// Shared types and sizing helpers for the floating-point normalisation-stage arbiter.
package fp_arb_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int NUM_REQ_MAX = 8;
   localparam int TAG_W_MAX = 3;

   // Operand bundle carries two floats; the result packs exp_fin and mant_shift into half a float.
   function automatic int payload_w(input int data_w);
      return 2 * data_w;
   endfunction

   function automatic int res_w(input int data_w);
      return data_w / 2;
   endfunction

   function automatic int tag_w(input int num_req);
      return (num_req > 1) ? $clog2(num_req) : 1;
   endfunction

   typedef struct packed {
      logic                 valid;
      logic [TAG_W_MAX-1:0] tag;
   } tag_rec_t;

endpackage

// File: rtl/fp_norm_arbiter_rr_pick.sv
// Combinational rotate-priority picker: lowest eligible index at or above rr_ptr, with wrap.
module rr_pick
   import fp_arb_pkg::*;
#(
   parameter int N     = 2,
   parameter int PTR_W = tag_w(N)
) (
   input  logic [N-1:0]     eligible,
   input  logic [PTR_W-1:0] rr_ptr,
   output logic [N-1:0]     grant
);

   localparam int SUM_W = PTR_W + 1;

   logic [SUM_W-1:0] sum;
   logic [PTR_W-1:0] idx;

   always_comb begin
      // NOTE: every variable gets a default before the loop so no path infers a latch.
      grant = '0;
      sum   = '0;
      idx   = '0;
      // Walk from farthest to nearest; the last hit written is the closest to rr_ptr.
      for (int k = N - 1; k >= 0; k--) begin
         sum = {1'b0, rr_ptr} + SUM_W'(k);
         if (sum >= SUM_W'(N)) begin
            sum = sum - SUM_W'(N);
         end
         idx = sum[PTR_W-1:0];
         if (eligible[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fp_norm_arbiter.sv
// Shares one fixed-latency normalisation stage among NUM_REQ requesters and routes results by tag.
// Define FP_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module fp_norm_arbiter
   import fp_arb_pkg::*;
#(
   parameter int DATA_W    = DATA_W_DEF,
   parameter int NUM_REQ   = 2,
   parameter int PIPE_LAT  = 2,
   parameter int PAYLOAD_W = payload_w(DATA_W),
   parameter int RES_W     = res_w(DATA_W)
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   output logic [NUM_REQ-1:0]           req_ready,
   input  logic [NUM_REQ*PAYLOAD_W-1:0] req_data,
   output logic                         stg_valid,
   output logic [PAYLOAD_W-1:0]         stg_data,
   input  logic [RES_W-1:0]             stg_res,
   output logic [NUM_REQ-1:0]           rsp_valid,
   output logic [NUM_REQ*RES_W-1:0]     rsp_data,
   input  logic [NUM_REQ-1:0]           rsp_ready
);

   localparam int TAG_W = tag_w(NUM_REQ);

   if (NUM_REQ < 1 || NUM_REQ > NUM_REQ_MAX) begin : g_bad_num_req
      $error("fp_norm_arbiter: NUM_REQ must be 1..8");
   end
   if (PIPE_LAT < 1) begin : g_bad_pipe_lat
      $error("fp_norm_arbiter: PIPE_LAT must be at least 1");
   end

   logic [NUM_REQ-1:0]   busy;
   logic [NUM_REQ-1:0]   eligible;
   logic [NUM_REQ-1:0]   grant;
   logic [NUM_REQ-1:0]   tap_hit;
   logic [NUM_REQ-1:0]   rsp_fire;
   logic [TAG_W-1:0]     pick_ptr;
   logic [TAG_W-1:0]     grant_idx;
   logic [PAYLOAD_W-1:0] grant_data;
   logic                 accept;
   tag_rec_t             tag_pipe [PIPE_LAT+1];
   tag_rec_t             tap;

   // Holding off grants during reset keeps req_ready at 0 while rst is high.
   assign eligible = req_valid & ~busy & {NUM_REQ{~rst}};

   rr_pick #(
      .N     (NUM_REQ),
      .PTR_W (TAG_W)
   ) u_pick (
      .eligible (eligible),
      .rr_ptr   (pick_ptr),
      .grant    (grant)
   );

   assign req_ready = grant;
   assign accept    = |grant;
   assign rsp_fire  = rsp_valid & rsp_ready;

   always_comb begin
      grant_idx  = '0;
      grant_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) begin
            grant_idx  = TAG_W'(i);
            grant_data = req_data[i*PAYLOAD_W +: PAYLOAD_W];
         end
      end
   end

`ifdef FP_ARB_FIXED_PRIO_EN
   assign pick_ptr = '0;
`else
   logic [TAG_W-1:0] rr_ptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr <= '0;
      end else if (accept) begin
         rr_ptr <= (grant_idx == TAG_W'(NUM_REQ - 1)) ? '0 : grant_idx + TAG_W'(1);
      end
   end

   assign pick_ptr = rr_ptr;
`endif

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         stg_valid <= 1'b0;
         stg_data  <= '0;
      end else begin
         stg_valid <= accept;
         if (accept) begin
            stg_data <= grant_data;
         end
      end
   end

   // Entry k is aligned with the stage's k-th cycle; entry PIPE_LAT lines up with stg_res.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the tag pipeline is reset because a stale valid tag would fabricate a response.
         for (int k = 0; k <= PIPE_LAT; k++) begin
            tag_pipe[k] <= '0;
         end
      end else begin
         tag_pipe[0] <= '{valid: accept, tag: TAG_W_MAX'(grant_idx)};
         for (int k = 1; k <= PIPE_LAT; k++) begin
            tag_pipe[k] <= tag_pipe[k-1];
         end
      end
   end

   assign tap = tag_pipe[PIPE_LAT];

   always_comb begin
      tap_hit = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         tap_hit[i] = tap.valid && (tap.tag == TAG_W_MAX'(i));
      end
   end

   // busy spans grant through response handshake; it drops one cycle after the handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy      <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
               busy[i] <= 1'b1;
            end else if (rsp_fire[i]) begin
               busy[i] <= 1'b0;
            end

            if (tap_hit[i]) begin
               rsp_valid[i]                 <= 1'b1;
               rsp_data[i*RES_W +: RES_W] <= stg_res;
            end else if (rsp_fire[i]) begin
               rsp_valid[i] <= 1'b0;
            end
         end
      end
   end

   // One outstanding operation per requester means a result can never land on a held slot.
   a_no_overwrite : assert property (@(posedge clk) disable iff (rst) ((tap_hit & rsp_valid) == '0));

endmodule

// File: tb/tb_fp_norm_arbiter.sv
// Self-checking bench for fp_norm_arbiter: grant tables, directed sequences and a response scoreboard.
module tb_fp_norm_arbiter;

   localparam int NUM_REQ   = 2;
   localparam int PIPE_LAT  = 2;
   localparam int PAYLOAD_W = 64;
   localparam int RES_W     = 16;

   logic                         clk = 1'b0;
   logic                         rst;
   logic [NUM_REQ-1:0]           req_valid;
   logic [NUM_REQ-1:0]           req_ready;
   logic [NUM_REQ*PAYLOAD_W-1:0] req_data;
   logic                         stg_valid;
   logic [PAYLOAD_W-1:0]         stg_data;
   logic [RES_W-1:0]             stg_res;
   logic [NUM_REQ-1:0]           rsp_valid;
   logic [NUM_REQ*RES_W-1:0]     rsp_data;
   logic [NUM_REQ-1:0]           rsp_ready;

   int n_vec  = 0;
   int n_miss = 0;
   int cyc    = 0;

   fp_norm_arbiter #(
      .DATA_W    (32),
      .NUM_REQ   (NUM_REQ),
      .PIPE_LAT  (PIPE_LAT),
      .PAYLOAD_W (PAYLOAD_W),
      .RES_W     (RES_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .stg_valid (stg_valid),
      .stg_data  (stg_data),
      .stg_res   (stg_res),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_ready (rsp_ready)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [RES_W-1:0] echo(input logic [PAYLOAD_W-1:0] d);
      return d[RES_W-1:0] ^ d[PAYLOAD_W-1 -: RES_W] ^ 16'h3C5A;
   endfunction

   // External stage model: result of the bundle issued PIPE_LAT cycles earlier.
   logic [PAYLOAD_W-1:0] stage_q [PIPE_LAT];

   always @(posedge clk) begin
      stage_q[0] <= stg_data;
      for (int k = 1; k < PIPE_LAT; k++) stage_q[k] <= stage_q[k-1];
   end

   assign stg_res = echo(stage_q[PIPE_LAT-1]);

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard: one entry per accepted request, retired on the response handshake.
   typedef struct {
      int               idx;
      logic [RES_W-1:0] data;
      int               due;
   } sb_t;

   sb_t                sb [$];
   logic [NUM_REQ-1:0] rsp_prev = '0;

   always @(negedge clk) begin : mon
      int k;
      if (rst) begin
         sb.delete();
         rsp_prev = '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
               sb.push_back('{i, echo(req_data[i*PAYLOAD_W +: PAYLOAD_W]), cyc + PIPE_LAT + 2});
            end
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (rsp_valid[i]) begin
               k = -1;
               for (int j = 0; j < sb.size(); j++) begin
                  if (sb[j].idx == i && k < 0) k = j;
               end
               check($sformatf("sb_pending_r%0d", i), 64'(k >= 0), 64'd1);
               if (k >= 0) begin
                  if (!rsp_prev[i]) check($sformatf("sb_latency_r%0d", i), 64'(cyc), 64'(sb[k].due));
                  check($sformatf("sb_data_r%0d", i), 64'(rsp_data[i*RES_W +: RES_W]), 64'(sb[k].data));
                  if (rsp_ready[i]) sb.delete(k);
               end
            end
         end
         rsp_prev = rsp_valid;
      end
   end

   typedef struct packed {
      logic       do_rst;
      logic [1:0] rv;
      logic [1:0] rr;
      logic [1:0] ready;
      logic       stgv;
      logic [1:0] rspv;
   } vec_t;

   vec_t vecs [$];

   task automatic add(input logic r, input logic [1:0] rv, input logic [1:0] rr,
                      input logic [1:0] rdy, input logic sv, input logic [1:0] rspv);
      vec_t v;
      v.do_rst = r;
      v.rv     = rv;
      v.rr     = rr;
      v.ready  = rdy;
      v.stgv   = sv;
      v.rspv   = rspv;
      vecs.push_back(v);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      req_valid = '0;
      rsp_ready = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_stg_valid", 64'(stg_valid), 64'd0);
      check("rst_stg_data", 64'(stg_data), 64'd0);
      check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      check("rst_rsp_data", 64'(rsp_data), 64'd0);
      step();
   endtask

   // Single request on requester 0 from an idle arbiter.
   task automatic single_req(input logic [PAYLOAD_W-1:0] d);
      req_data[0 +: PAYLOAD_W] = d;
      req_valid = 2'b01;
      rsp_ready = 2'b01;
      @(negedge clk);
      check("t1_ready_c0", 64'(req_ready), 64'd1);
      check("t1_stgv_c0", 64'(stg_valid), 64'd0);
      step();
      @(negedge clk);
      check("t1_stgv_c1", 64'(stg_valid), 64'd1);
      check("t1_stgd_c1", stg_data, d);
      check("t1_ready_c1", 64'(req_ready), 64'd0);
      for (int c = 2; c < 4; c++) begin
         step();
         @(negedge clk);
         check($sformatf("t1_rspv_c%0d", c), 64'(rsp_valid), 64'd0);
         check($sformatf("t1_ready_c%0d", c), 64'(req_ready), 64'd0);
      end
      step();
      req_valid = 2'b00;
      @(negedge clk);
      check("t1_rspv_c4", 64'(rsp_valid), 64'd1);
      check("t1_rspd_c4", 64'(rsp_data[0 +: RES_W]), 64'(echo(d)));
      step();
      @(negedge clk);
      check("t1_rspv_c5", 64'(rsp_valid), 64'd0);
      step();
   endtask

   initial begin
      rst       = 1'b1;
      req_valid = '0;
      rsp_ready = '0;
      req_data  = '0;

      // Both requesters continuously valid, responses always accepted.
      add(1, 2'b11, 2'b11, 2'b01, 0, 2'b00);
      add(0, 2'b11, 2'b11, 2'b10, 1, 2'b00);
      add(0, 2'b11, 2'b11, 2'b00, 1, 2'b00);
      add(0, 2'b11, 2'b11, 2'b00, 0, 2'b00);
      add(0, 2'b11, 2'b11, 2'b00, 0, 2'b01);
      add(0, 2'b11, 2'b11, 2'b01, 0, 2'b10);
      add(0, 2'b11, 2'b11, 2'b10, 1, 2'b00);
      add(0, 2'b11, 2'b11, 2'b00, 1, 2'b00);
      add(0, 2'b11, 2'b11, 2'b00, 0, 2'b00);
      add(0, 2'b11, 2'b11, 2'b00, 0, 2'b01);
      add(0, 2'b11, 2'b11, 2'b01, 0, 2'b10);
      add(0, 2'b11, 2'b11, 2'b10, 1, 2'b00);

      // Handshake plus req_valid on requester 0 (c4, c9), then a priority-dependent contest.
      add(1, 2'b01, 2'b11, 2'b01, 0, 2'b00);
      add(0, 2'b01, 2'b11, 2'b00, 1, 2'b00);
      add(0, 2'b01, 2'b11, 2'b00, 0, 2'b00);
      add(0, 2'b01, 2'b11, 2'b00, 0, 2'b00);
      add(0, 2'b01, 2'b11, 2'b00, 0, 2'b01);
      add(0, 2'b01, 2'b11, 2'b01, 0, 2'b00);
      add(0, 2'b01, 2'b11, 2'b00, 1, 2'b00);
      add(0, 2'b01, 2'b11, 2'b00, 0, 2'b00);
      add(0, 2'b01, 2'b11, 2'b00, 0, 2'b00);
      add(0, 2'b01, 2'b11, 2'b00, 0, 2'b01);
`ifdef FP_ARB_FIXED_PRIO_EN
      add(0, 2'b11, 2'b11, 2'b01, 0, 2'b00);
      add(0, 2'b11, 2'b11, 2'b10, 1, 2'b00);
`else
      add(0, 2'b11, 2'b11, 2'b10, 0, 2'b00);
      add(0, 2'b11, 2'b11, 2'b01, 1, 2'b00);
`endif

      // Requester 1 response held for 10 cycles (c5..c14) while requester 0 keeps issuing.
      add(1, 2'b11, 2'b01, 2'b01, 0, 2'b00);
      add(0, 2'b11, 2'b01, 2'b10, 1, 2'b00);
      add(0, 2'b11, 2'b01, 2'b00, 1, 2'b00);
      add(0, 2'b11, 2'b01, 2'b00, 0, 2'b00);
      add(0, 2'b11, 2'b01, 2'b00, 0, 2'b01);
      add(0, 2'b11, 2'b01, 2'b01, 0, 2'b10);
      add(0, 2'b11, 2'b01, 2'b00, 1, 2'b10);
      add(0, 2'b11, 2'b01, 2'b00, 0, 2'b10);
      add(0, 2'b11, 2'b01, 2'b00, 0, 2'b10);
      add(0, 2'b11, 2'b01, 2'b00, 0, 2'b11);
      add(0, 2'b11, 2'b01, 2'b01, 0, 2'b10);
      add(0, 2'b11, 2'b01, 2'b00, 1, 2'b10);
      add(0, 2'b11, 2'b01, 2'b00, 0, 2'b10);
      add(0, 2'b11, 2'b01, 2'b00, 0, 2'b10);
      add(0, 2'b11, 2'b01, 2'b00, 0, 2'b11);
      add(0, 2'b11, 2'b11, 2'b01, 0, 2'b10);
      add(0, 2'b11, 2'b11, 2'b10, 1, 2'b00);
      add(0, 2'b11, 2'b11, 2'b00, 1, 2'b00);

      step();
      do_reset();
      single_req(64'hA5);

      for (int v = 0; v < vecs.size(); v++) begin
         if (vecs[v].do_rst) do_reset();
         req_valid = vecs[v].rv;
         rsp_ready = vecs[v].rr;
         for (int i = 0; i < NUM_REQ; i++) req_data[i*PAYLOAD_W +: PAYLOAD_W] = {$urandom, $urandom};
         @(negedge clk);
         check($sformatf("v%0d_req_ready", v), 64'(req_ready), 64'(vecs[v].ready));
         check($sformatf("v%0d_stg_valid", v), 64'(stg_valid), 64'(vecs[v].stgv));
         check($sformatf("v%0d_rsp_valid", v), 64'(rsp_valid), 64'(vecs[v].rspv));
         step();
      end

      // Reset one cycle after an accept: the in-flight result must never appear.
      do_reset();
      req_data[0 +: PAYLOAD_W] = 64'h1234_5678_9ABC_DEF0;
      req_valid = 2'b01;
      rsp_ready = 2'b01;
      @(negedge clk);
      check("mid_rst_ready_c0", 64'(req_ready), 64'd1);
      step();
      rst       = 1'b1;
      req_valid = 2'b00;
      step();
      rst = 1'b0;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check($sformatf("mid_rst_rspv_%0d", c), 64'(rsp_valid), 64'd0);
         check($sformatf("mid_rst_ready_%0d", c), 64'(req_ready), 64'd0);
         step();
      end
      single_req(64'hA5);

      repeat (2) step();
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/fp_norm_arbiter.md
# fp_norm_arbiter

Round-robin arbiter that shares one fixed-latency exponent/normalisation stage among several floating-point requesters. Typical requesters are the adder and multiplier mantissa paths. The block accepts one operand bundle per cycle from a chosen requester and drives the shared stage. It tracks each in-flight operation with a tag pipeline and routes the stage result back to the requester that issued it. Each requester has at most one outstanding operation, so the stage never needs backpressure.

## Interface
- DATA_W, 32: float width; sets the default payload and result widths.
- NUM_REQ, 2: number of requesters, 2..8.
- PIPE_LAT, 2: fixed latency of the shared stage in cycles, ≥1.
- PAYLOAD_W, 64: width of the operand bundle sent to the stage.
- RES_W, 16: width of the stage result (exp_fin plus mant_shift).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_ready  out  NUM_REQ  per-requester accept (one-hot or zero).
- req_data  in  NUM_REQ*PAYLOAD_W  operand bundles; requester i occupies slice i.
- stg_valid  out  1  issue strobe to the shared stage.
- stg_data  out  PAYLOAD_W  bundle issued to the stage.
- stg_res  in  RES_W  stage output, valid exactly PIPE_LAT cycles after stg_valid.
- rsp_valid  out  NUM_REQ  per-requester result valid.
- rsp_data  out  NUM_REQ*RES_W  per-requester held result.
- rsp_ready  in  NUM_REQ  per-requester result accept.

## Operation
- busy[i] is set when requester i is granted. It is cleared the cycle after rsp_valid[i] && rsp_ready[i].
- eligible[i] = req_valid[i] && !busy[i].
- Grant selects one eligible requester, searching from rr_ptr upward with wrap-around.
- req_ready is combinational from req_valid and the registered state only. It is the one-hot grant, or 0 when nothing is eligible.
- On accept (req_valid[i] && req_ready[i]):
  - stg_data <= req_data slice i and stg_valid <= 1 at the next edge.
  - The tag i with a valid bit enters the tag pipeline, which has depth PIPE_LAT+1.
  - rr_ptr <= (i+1) mod NUM_REQ.
- With no accept: stg_valid <= 0, stg_data holds its previous value, rr_ptr holds.
- When a valid tag reaches the tap aligned with stg_res:
  - The rsp_data slice for that tag is loaded with stg_res.
  - The matching rsp_valid is set.
- rsp_valid[i] stays asserted and rsp_data slice i stays stable until rsp_ready[i]. rsp_ready without rsp_valid is ignored.
- Stage results arriving without a valid tag are discarded.

## Timing
- Accept at edge t. stg_valid is high during cycle t+1. stg_res is sampled at edge t+1+PIPE_LAT. rsp_valid is high from cycle t+2+PIPE_LAT.
- End-to-end latency is PIPE_LAT+2 cycles.
- Peak throughput is one issue per cycle. Each requester can issue at most once per PIPE_LAT+3 cycles (including the handshake cycle).
- Simultaneous response handshake and new req_valid on the same requester: no grant that cycle; the requester is grantable the next cycle.
- A result arriving for requester i while i is already holding is impossible by construction; flag it with an assertion.
- Reset values:
  - req_ready, stg_valid, rsp_valid: 0.
  - stg_data, rsp_data: 0.
  - rr_ptr: 0; busy: 0; tag pipeline: all invalid.
- Reset mid-operation drops all in-flight tags. Stage outputs during the following PIPE_LAT cycles are discarded.
- Single-requester configuration (NUM_REQ=1, allowed only for test): rr_ptr is constant 0.

## Configuration
- FP_ARB_FIXED_PRIO_EN defined: fixed priority; the lowest eligible index wins. rr_ptr is removed.
- FP_ARB_FIXED_PRIO_EN undefined (default): round-robin as described under Operation.
- Latency, tagging and response behaviour are identical in both builds.

## Structure
- Package fp_arb_pkg holds:
  - function tag_w(NUM_REQ) = max(1, $clog2(NUM_REQ));
  - tag record type {valid, tag};
  - RES_W / PAYLOAD_W defaults derived from DATA_W.
- Sub-module rr_pick: combinational rotate-priority picker.
  - Inputs: eligible vector, rr_ptr.
  - Output: one-hot grant.
  - Under FP_ARB_FIXED_PRIO_EN, rr_ptr is tied to 0.
- The shared normalisation stage is external; this block never instantiates it.

## Test plan
- Single request, NUM_REQ=2, PIPE_LAT=2: req_valid[0]=1 with data 0xA5. Required:
  - req_ready[0]=1 in cycle 0;
  - stg_valid=1 in cycle 1;
  - rsp_valid[0]=1 in cycle 4 carrying the stage echo;
  - req_ready[0]=0 while busy.
- Both requesters valid continuously, rsp_ready tied 1. Required:
  - grants alternate 0,1,0,1;
  - no requester is granted again before its response handshake plus 1 cycle.
- Response backpressure: hold rsp_ready[1]=0 for 10 cycles. Required:
  - rsp_valid[1] and rsp_data stay stable;
  - requester 1 gets no new grant;
  - requester 0 keeps being served.
- Simultaneous response handshake and req_valid on requester 0: no grant that cycle; grant in the next cycle.
- Reset asserted 1 cycle after accept: rsp_valid stays 0 for all following cycles; busy clears; the next request behaves as in test 1.
- FP_ARB_FIXED_PRIO_EN build, both requesters always valid, rsp_ready=1: requester 0 wins every time it is eligible; requester 1 is granted only while 0 is busy.
